// File: rtl/rhs_spi_responder.sv
// rhs_spi_responder: RHS2116 chip-side SPI emulator for one headstage port.
// It decodes CONVERT/READ/WRITE/CALIBRATE/CLEAR words from the rhs_256 master
// and returns each result two words later on MISO, so rhs_256 (including its
// oversample_offset tuning) can be exercised in loopback without hardware.
// SCLK, CS and MOSI are oversampled on clk, which must run at least 6x SCLK.
// Optional build macro RHS_RESPONDER_DC_DATA_EN fills the CONVERT low half with
// emulated 10-bit low-gain DC data; without it the low half reads as zero.
module rhs_spi_responder #(
  parameter int STARTING_SEED = 0,
  parameter int CHIP_ID       = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        cmd_valid,
  output logic        cmd_error,
  output logic [31:0] last_cmd,
  output logic [15:0] frame_count
);

  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic        cs_armed_q, cs_armed_d;
  logic [31:0] rx_shift_q, rx_shift_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] resp_pipe_q [2];
  logic [31:0] resp_pipe_d [2];
  logic [15:0] reg_file_q [NUM_REGS];
  logic [15:0] reg_file_d [NUM_REGS];
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_error_q, cmd_error_d;
  logic [31:0] last_cmd_q, last_cmd_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall;

  logic [5:0]  cmd_chan;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [15:0] conv_ac;
  logic [15:0] conv_dc;
  logic        addr_in_range;
  logic [31:0] dec_result;
  logic [15:0] dec_frame_count;
  logic        dec_reg_we;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Decode the received word into its result, frame-count update and register write.
  always_comb begin
    cmd_chan        = rx_shift_q[21:16];
    cmd_addr        = rx_shift_q[23:16];
    cmd_data        = rx_shift_q[15:0];
    conv_ac         = 16'(STARTING_SEED) + {10'b0, cmd_chan} + frame_count_q;
`ifdef RHS_RESPONDER_DC_DATA_EN
    conv_dc         = {6'b0, cmd_chan[3:0], frame_count_q[5:0]};
`else
    conv_dc         = 16'h0000;
`endif
    addr_in_range   = ({24'b0, cmd_addr} < 32'(NUM_REGS));
    dec_result      = 32'h0000_0000;
    dec_frame_count = frame_count_q;
    dec_reg_we      = 1'b0;
    case (rx_shift_q[31:30])
      2'b00: begin
        if (cmd_chan < 6'd16) begin
          dec_result = {conv_ac, conv_dc};
          if (cmd_chan == 6'd15) begin
            dec_frame_count = frame_count_q + 16'd1;
          end
        end else begin
          dec_result = 32'hFFFF_FFFF;
        end
      end
      2'b10: begin
        dec_result = {16'hFFFF, cmd_data};
        dec_reg_we = addr_in_range;
      end
      2'b11: begin
        if (addr_in_range) begin
          dec_result = {16'h0000, reg_file_q[cmd_addr[REG_AW-1:0]]};
        end else begin
          case (cmd_addr)
            8'd251:  dec_result = 32'h0000_0049;
            8'd252:  dec_result = 32'h0000_004E;
            8'd253:  dec_result = 32'h0000_0054;
            8'd254:  dec_result = 32'h0000_0041;
            8'd255:  dec_result = 32'(CHIP_ID);
            default: dec_result = 32'h0000_0000;
          endcase
        end
      end
      default: begin
        if (rx_shift_q == 32'h6A00_0000) begin
          dec_frame_count = 16'h0000;
        end
      end
    endcase
  end

  // Next-state logic: synchronizers, framing FSM, shift registers and result pipeline.
  always_comb begin
    state_d       = state_q;
    sclk_sync_d   = {sclk_sync_q[0], SCLK};
    cs_sync_d     = {cs_sync_q[0], CS};
    mosi_sync_d   = {mosi_sync_q[0], MOSI};
    sclk_prev_d   = sclk_s;
    cs_armed_d    = cs_armed_q | cs_s;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    resp_pipe_d   = resp_pipe_q;
    reg_file_d    = reg_file_q;
    cmd_valid_d   = 1'b0;
    cmd_error_d   = 1'b0;
    last_cmd_d    = last_cmd_q;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (!cs_s && cs_armed_q) begin
          tx_shift_d = resp_pipe_q[1];
          rx_shift_d = 32'h0000_0000;
          bit_cnt_d  = 6'd0;
          cs_armed_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_d = DONE;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[30:0], mosi_s};
            if (bit_cnt_q != 6'd63) begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
          if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[30:0], 1'b0};
          end
        end
      end
      DONE: begin
        tx_shift_d = 32'h0000_0000;
        if (bit_cnt_q == 6'd32) begin
          cmd_valid_d    = 1'b1;
          last_cmd_d     = rx_shift_q;
          resp_pipe_d[1] = resp_pipe_q[0];
          resp_pipe_d[0] = dec_result;
          frame_count_d  = dec_frame_count;
          if (dec_reg_we) begin
            reg_file_d[cmd_addr[REG_AW-1:0]] = cmd_data;
          end
        end else begin
          cmd_error_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, abandoning any partial word silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sclk_sync_q   <= 2'b00;
      cs_sync_q     <= 2'b00;
      mosi_sync_q   <= 2'b00;
      sclk_prev_q   <= 1'b0;
      cs_armed_q    <= 1'b0;
      rx_shift_q    <= 32'h0000_0000;
      tx_shift_q    <= 32'h0000_0000;
      bit_cnt_q     <= 6'd0;
      resp_pipe_q   <= '{default: 32'h0000_0000};
      reg_file_q    <= '{default: 16'h0000};
      cmd_valid_q   <= 1'b0;
      cmd_error_q   <= 1'b0;
      last_cmd_q    <= 32'h0000_0000;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_armed_q    <= cs_armed_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      resp_pipe_q   <= resp_pipe_d;
      reg_file_q    <= reg_file_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_error_q   <= cmd_error_d;
      last_cmd_q    <= last_cmd_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign MISO        = tx_shift_q[31];
  assign cmd_valid   = cmd_valid_q;
  assign cmd_error   = cmd_error_q;
  assign last_cmd    = last_cmd_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_rhs_spi_responder.sv
// tb_rhs_spi_responder: directed scoreboard bench for rhs_spi_responder.
// The stimulus task acts as the SPI master and queues the expected MISO word
// and command-accept record; two monitors pop and compare independently.
module tb_rhs_spi_responder;

  localparam int SEED = 16;

  typedef struct packed {
    logic [31:0] word;
    logic [15:0] fc;
  } cmd_exp_t;

  logic        clk;
  logic        rstn;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        cmd_valid;
  logic        cmd_error;
  logic [31:0] last_cmd;
  logic [15:0] frame_count;

  int          check_count = 0;
  int          pass_count = 0;
  int          valid_count = 0;
  int          err_count = 0;
  int          exp_valid = 0;
  logic [31:0] exp_miso_q [$];
  cmd_exp_t    exp_cmd_q [$];
  logic [31:0] res_hist [$];

  logic        mon_prev_cs = 1'b1;
  int          mon_bits = 0;
  logic [31:0] mon_word = 32'h0;

  rhs_spi_responder #(
    .STARTING_SEED(SEED),
    .CHIP_ID(32),
    .NUM_REGS(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .SCLK(sclk),
    .CS(cs),
    .MOSI(mosi),
    .MISO(miso),
    .cmd_valid(cmd_valid),
    .cmd_error(cmd_error),
    .last_cmd(last_cmd),
    .frame_count(frame_count)
  );

  // 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value, count it, and report a failure on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Expected CONVERT result for channel c taken while frame_count equals fc.
  function automatic logic [31:0] expConvert(input int c, input int fc);
    logic [15:0] ac;
    logic [15:0] dc;
    logic [3:0]  c4;
    logic [5:0]  f6;
    ac = 16'(SEED + c + fc);
    c4 = 4'(c);
    f6 = 6'(fc);
`ifdef RHS_RESPONDER_DC_DATA_EN
    dc = {6'b0, c4, f6};
`else
    dc = 16'h0000;
    if (c4 == 4'hF && f6 == 6'h3F) dc = 16'h0000;
`endif
    return {ac, dc};
  endfunction

  // Act as the SPI master for one frame of nbits; full frames queue their expectations.
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input bit raise_cs,
                               input logic [31:0] exp_res, input logic [15:0] exp_fc);
    cmd_exp_t ce;
    if (nbits == 32 && raise_cs) begin
      exp_miso_q.push_back((res_hist.size() >= 2) ? res_hist[res_hist.size() - 2] : 32'h0);
      res_hist.push_back(exp_res);
      ce.word = word;
      ce.fc   = exp_fc;
      exp_cmd_q.push_back(ce);
      exp_valid++;
    end
    @(negedge clk);
    cs   = 1'b0;
    mosi = word[31];
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[31 - i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    if (raise_cs) begin
      cs = 1'b1;
      repeat (12) @(negedge clk);
    end
  endtask

  // MISO monitor: capture bits at SCLK rise and compare each full frame.
  initial begin : miso_monitor
    forever begin
      @(posedge sclk or cs);
      if (cs !== mon_prev_cs) begin
        if (!cs) begin
          mon_bits = 0;
          mon_word = 32'h0;
        end else if (mon_bits == 32) begin
          if (exp_miso_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL misoWord: got 0x%08h with no expected word queued", mon_word);
          end else begin
            checkOutput("misoWord", mon_word, exp_miso_q.pop_front());
          end
        end
        mon_prev_cs = cs;
      end else if (sclk && !cs) begin
        mon_word = {mon_word[30:0], miso};
        mon_bits++;
      end
    end
  end

  // Command monitor: compare last_cmd and frame_count on every accepted word.
  always @(negedge clk) begin
    if (rstn && cmd_error) err_count++;
    if (rstn && cmd_valid) begin
      cmd_exp_t ce;
      valid_count++;
      if (exp_cmd_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL cmdValid: got word 0x%08h with no expected command queued", last_cmd);
      end else begin
        ce = exp_cmd_q.pop_front();
        checkOutput("lastCmd", last_cmd, ce.word);
        checkOutput("frameCount", {16'h0, frame_count}, {16'h0, ce.fc});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int err_snap;
    rstn = 1'b0;
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("resetMiso", {31'h0, miso}, 32'h0);
    checkOutput("resetCmdValid", {31'h0, cmd_valid}, 32'h0);
    checkOutput("resetCmdError", {31'h0, cmd_error}, 32'h0);
    checkOutput("resetLastCmd", last_cmd, 32'h0);
    checkOutput("resetFrameCount", {16'h0, frame_count}, 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] converts, write/read, identity reads");
    applyStimulus(32'h0000_0000, 32, 1, expConvert(0, 0), 16'd0);
    applyStimulus(32'h0001_0000, 32, 1, expConvert(1, 0), 16'd0);
    applyStimulus(32'h0002_0000, 32, 1, expConvert(2, 0), 16'd0);
    applyStimulus(32'h8003_BEEF, 32, 1, 32'hFFFF_BEEF, 16'd0);
    applyStimulus(32'hC003_0000, 32, 1, 32'h0000_BEEF, 16'd0);
    applyStimulus(32'h0000_0000, 32, 1, expConvert(0, 0), 16'd0);
    applyStimulus(32'h0000_0000, 32, 1, expConvert(0, 0), 16'd0);
    applyStimulus(32'hC0FF_0000, 32, 1, 32'h0000_0020, 16'd0);
    applyStimulus(32'hC0FB_0000, 32, 1, 32'h0000_0049, 16'd0);
    applyStimulus(32'h8014_1234, 32, 1, 32'hFFFF_1234, 16'd0);
    applyStimulus(32'hC014_0000, 32, 1, 32'h0000_0000, 16'd0);
    applyStimulus(32'hC0FE_0000, 32, 1, 32'h0000_0041, 16'd0);
    applyStimulus(32'h0010_0000, 32, 1, 32'hFFFF_FFFF, 16'd0);
    applyStimulus(32'h5500_0000, 32, 1, 32'h0000_0000, 16'd0);
    applyStimulus(32'h4000_0000, 32, 1, 32'h0000_0000, 16'd0);

    $display("[TB] three rounds of channels 0..15, then CLEAR");
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 16; c++) begin
        applyStimulus({10'b0, 6'(c), 16'h0}, 32, 1, expConvert(c, r),
                      16'((c == 15) ? r + 1 : r));
      end
    end
    applyStimulus(32'h6A00_0000, 32, 1, 32'h0000_0000, 16'd0);

    $display("[TB] short frame of 20 bits");
    err_snap = err_count;
    applyStimulus(32'h0005_0000, 20, 1, 32'h0, 16'd0);
    checkOutput("shortFrameError", 32'(err_count - err_snap), 32'd1);
    checkOutput("shortFrameNoValid", 32'(valid_count), 32'(exp_valid));
    applyStimulus(32'h0001_0000, 32, 1, expConvert(1, 0), 16'd0);

    $display("[TB] reset in the middle of a word");
    err_snap = err_count;
    applyStimulus(32'hC0FF_0000, 12, 0, 32'h0, 16'd0);
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midResetMiso", {31'h0, miso}, 32'h0);
    checkOutput("midResetLastCmd", last_cmd, 32'h0);
    checkOutput("midResetFrameCount", {16'h0, frame_count}, 32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("midResetNoError", 32'(err_count - err_snap), 32'd0);
    res_hist.delete();
    applyStimulus(32'hC003_0000, 32, 1, 32'h0000_0000, 16'd0);
    applyStimulus(32'h000F_0000, 32, 1, expConvert(15, 0), 16'd1);
    applyStimulus(32'h0000_0000, 32, 1, expConvert(0, 1), 16'd1);
    applyStimulus(32'h5500_0000, 32, 1, 32'h0000_0000, 16'd1);

    repeat (20) @(negedge clk);
    checkOutput("misoQueueDrained", 32'(exp_miso_q.size()), 32'd0);
    checkOutput("cmdQueueDrained", 32'(exp_cmd_q.size()), 32'd0);
    checkOutput("validCount", 32'(valid_count), 32'(exp_valid));
    checkOutput("errorCount", 32'(err_count), 32'd1);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
